// File: rtl/fx2_endpoint_arbiter_if.sv
// Handshake/bus bundle between the FX2 endpoint arbiter and the transfer
// engines / pin layer. The arbiter uses the slave modport; the engine side
// (or a testbench) uses the master modport.
interface fx2_endpoint_arbiter_if;
  logic [2:0] req_i;        // [0] ctrl in, [1] ctrl out, [2] event out
  logic [2:0] block_i;      // endpoint not ready flags, same bit order
  logic       beat_i;       // active engine moved one byte
  logic       done_i;       // active engine finished
  logic [2:0] gnt_o;        // one-hot grant
  logic       go_o;         // address settled, engine may start
  logic [1:0] fifoadr_o;    // FX2 FIFOADR
  logic       sloe_o;       // 1 = FX2 drives FD
  logic       burst_end_o;  // byte limit reached
  logic       abort_o;      // watchdog release
  logic       busy_o;       // arbiter not idle
  logic [2:0] state_o;      // debug state

  modport slave (
    input  req_i, block_i, beat_i, done_i,
    output gnt_o, go_o, fifoadr_o, sloe_o, burst_end_o, abort_o, busy_o, state_o
  );

  modport master (
    output req_i, block_i, beat_i, done_i,
    input  gnt_o, go_o, fifoadr_o, sloe_o, burst_end_o, abort_o, busy_o, state_o
  );
endinterface

// File: rtl/fx2_endpoint_arbiter.sv
// fx2_endpoint_arbiter: shares the FX2 slave-FIFO bus between the ctrl-in
// (EP2OUT), ctrl-out (EP4IN) and event-out (EP6IN) engines. One engine is
// granted at a time; FIFOADR/SLOE are driven, the address is allowed to
// settle, then the engine runs until done, the per-grant byte limit, or
// (optionally) a beat-less watchdog timeout.
// Optional feature macro: FX2ARB_WATCHDOG_EN enables the ACTIVE watchdog;
// without it abort_o is constant 0.
module fx2_endpoint_arbiter #(
  parameter int MAX_BURST   = 512,
  parameter int ADDR_SETTLE = 2,
  parameter int EV_WEIGHT   = 4,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                        CLK,
  input  logic                        rst_i,
  fx2_endpoint_arbiter_if.slave       bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [9:0]  BURST_LAST  = 10'(MAX_BURST - 1);
  localparam logic [2:0]  SETTLE_LOAD = 3'(ADDR_SETTLE - 1);
  localparam logic [7:0]  WEIGHT      = 8'(EV_WEIGHT);
  localparam logic [12:0] WDOG_LAST   = 13'(WDOG_CYCLES - 1);

  // Out-of-range settings would silently wrap the narrow counters.
  if (ADDR_SETTLE < 1 || ADDR_SETTLE > 7 || MAX_BURST < 1 || MAX_BURST > 1024 ||
      EV_WEIGHT < 0 || EV_WEIGHT > 255 || WDOG_CYCLES < 2 || WDOG_CYCLES > 8192) begin : g_bad_param
    $error("fx2_endpoint_arbiter: parameter out of range");
  end

  state_t      state_reg,     state_next;
  logic [2:0]  gnt_reg,       gnt_next;
  logic [1:0]  fifoadr_reg,   fifoadr_next;
  logic        sloe_reg,      sloe_next;
  logic        go_reg,        go_next;
  logic        burst_end_reg, burst_end_next;
  logic [7:0]  streak_reg,    streak_next;
  logic        last_ctrl_reg, last_ctrl_next;  // 0 = ctrl in, 1 = ctrl out
  logic [2:0]  settle_reg,    settle_next;
  logic [9:0]  count_reg,     count_next;
`ifdef FX2ARB_WATCHDOG_EN
  logic [12:0] wdog_reg,      wdog_next;
  logic        abort_reg,     abort_next;
`endif

  logic [2:0]  eligible;
  logic [2:0]  pick_gnt;
  logic [1:0]  pick_addr;
  logic        ctrl_any;

  // Per-endpoint eligibility: requesting and not blocked.
  for (genvar gi = 0; gi < 3; gi++) begin : g_elig
    assign eligible[gi] = bus.req_i[gi] & ~bus.block_i[gi];
  end

  // Winner selection: weighted event priority, round robin between ctrl engines.
  always_comb begin
    pick_gnt = 3'b000;
    ctrl_any = eligible[0] | eligible[1];
    if (eligible[2] && ((streak_reg < WEIGHT) || !ctrl_any)) begin
      pick_gnt = 3'b100;
    end else if (eligible[0] && eligible[1]) begin
      pick_gnt = last_ctrl_reg ? 3'b001 : 3'b010;
    end else if (eligible[0]) begin
      pick_gnt = 3'b001;
    end else if (eligible[1]) begin
      pick_gnt = 3'b010;
    end
    pick_addr = {pick_gnt[2], pick_gnt[1]};
  end

  // Next-state and registered-output logic for the grant sequencer.
  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    fifoadr_next   = fifoadr_reg;
    sloe_next      = sloe_reg;
    go_next        = 1'b0;
    burst_end_next = 1'b0;
    streak_next    = streak_reg;
    last_ctrl_next = last_ctrl_reg;
    settle_next    = settle_reg;
    count_next     = count_reg;
`ifdef FX2ARB_WATCHDOG_EN
    wdog_next      = wdog_reg;
    abort_next     = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (|eligible) begin
          gnt_next     = pick_gnt;
          fifoadr_next = pick_addr;
          if (pick_gnt[2]) begin
            if (streak_reg < WEIGHT) streak_next = streak_reg + 8'd1;
          end else begin
            streak_next    = 8'd0;
            last_ctrl_next = pick_gnt[1];
          end
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // FX2 only drives FD for the inbound (EP2OUT) direction.
        sloe_next   = gnt_reg[0];
        settle_next = SETTLE_LOAD;
        state_next  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_reg == 3'd0) begin
          go_next    = 1'b1;
          state_next = ST_ACTIVE;
        end else begin
          settle_next = settle_reg - 3'd1;
        end
      end
      ST_ACTIVE: begin
        if (bus.done_i || (bus.beat_i && count_reg == BURST_LAST)
`ifdef FX2ARB_WATCHDOG_EN
            || (!bus.beat_i && wdog_reg == WDOG_LAST)
`endif
           ) begin
          // Done takes precedence: no limit/abort pulse on a clean finish.
          if (!bus.done_i) begin
            if (bus.beat_i) burst_end_next = 1'b1;
`ifdef FX2ARB_WATCHDOG_EN
            else            abort_next     = 1'b1;
`endif
          end
          gnt_next     = 3'b000;
          fifoadr_next = 2'b00;
          sloe_next    = 1'b1;
          count_next   = 10'd0;
          state_next   = ST_RELEASE;
`ifdef FX2ARB_WATCHDOG_EN
          wdog_next    = 13'd0;
`endif
        end else begin
          if (bus.beat_i) count_next = count_reg + 10'd1;
`ifdef FX2ARB_WATCHDOG_EN
          wdog_next = bus.beat_i ? 13'd0 : wdog_reg + 13'd1;
`endif
        end
      end
      ST_RELEASE: begin
        gnt_next     = 3'b000;
        fifoadr_next = 2'b00;
        sloe_next    = 1'b1;
        count_next   = 10'd0;
        state_next   = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= 3'b000;
      fifoadr_reg   <= 2'b00;
      sloe_reg      <= 1'b1;
      go_reg        <= 1'b0;
      burst_end_reg <= 1'b0;
      streak_reg    <= 8'd0;
      last_ctrl_reg <= 1'b1;
      settle_reg    <= 3'd0;
      count_reg     <= 10'd0;
`ifdef FX2ARB_WATCHDOG_EN
      wdog_reg      <= 13'd0;
      abort_reg     <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      fifoadr_reg   <= fifoadr_next;
      sloe_reg      <= sloe_next;
      go_reg        <= go_next;
      burst_end_reg <= burst_end_next;
      streak_reg    <= streak_next;
      last_ctrl_reg <= last_ctrl_next;
      settle_reg    <= settle_next;
      count_reg     <= count_next;
`ifdef FX2ARB_WATCHDOG_EN
      wdog_reg      <= wdog_next;
      abort_reg     <= abort_next;
`endif
    end
  end

  assign bus.gnt_o       = gnt_reg;
  assign bus.go_o        = go_reg;
  assign bus.fifoadr_o   = fifoadr_reg;
  assign bus.sloe_o      = sloe_reg;
  assign bus.burst_end_o = burst_end_reg;
  assign bus.busy_o      = (state_reg != ST_IDLE);
  assign bus.state_o     = state_reg;
`ifdef FX2ARB_WATCHDOG_EN
  assign bus.abort_o     = abort_reg;
`else
  assign bus.abort_o     = 1'b0;
`endif

endmodule

// File: tb/tb_fx2_endpoint_arbiter.sv
// Testbench for fx2_endpoint_arbiter: randomized and directed grant
// sequences checked against a transaction-level arbitration model.
module tb_fx2_endpoint_arbiter;
  localparam int MAX_BURST   = 512;
  localparam int ADDR_SETTLE = 2;
  localparam int EV_WEIGHT   = 4;
  localparam int WDOG_CYCLES = 4096;

  logic CLK = 1'b0;
  logic rst_i;
  always #5 CLK = ~CLK;

  fx2_endpoint_arbiter_if bus();

  fx2_endpoint_arbiter #(
    .MAX_BURST(MAX_BURST), .ADDR_SETTLE(ADDR_SETTLE),
    .EV_WEIGHT(EV_WEIGHT), .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .CLK(CLK),
    .rst_i(rst_i),
    .bus(bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int txn_no  = 0;

  // Reference model state: consecutive event grants and last ctrl winner.
  int m_streak;
  int m_last_ctrl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gnt_index(input logic [2:0] g);
    case (g)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  function automatic void model_reset();
    m_streak    = 0;
    m_last_ctrl = 1;
  endfunction

  // Winner per arbitration rules; updates model history.
  function automatic int model_pick(input logic [2:0] elig);
    int w;
    bit ctrl_any;
    ctrl_any = elig[0] || elig[1];
    if (elig[2] && (m_streak < EV_WEIGHT || !ctrl_any)) w = 2;
    else if (elig[0] && elig[1]) w = (m_last_ctrl == 0) ? 1 : 0;
    else if (elig[0]) w = 0;
    else w = 1;
    if (w == 2) begin
      if (m_streak < EV_WEIGHT) m_streak++;
    end else begin
      m_streak    = 0;
      m_last_ctrl = w;
    end
    return w;
  endfunction

  // Wait (bounded) for a grant and then for go_o; returns observed winner.
  task automatic grant_and_go(input int exp_w, input bit early_beats, output int win, output bit ok);
    bit seen;
    int lat;
    seen = 0;
    win  = 3;
    ok   = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge CLK);
      if (bus.gnt_o != 3'b000) begin seen = 1; break; end
    end
    check_eq("grant_seen", 32'(seen), 1);
    if (!seen) return;
    win = gnt_index(bus.gnt_o);
    check_eq("gnt", 32'(bus.gnt_o), 32'(3'b001 << exp_w));
    check_eq("fifoadr", 32'(bus.fifoadr_o), 32'(exp_w));
    if (early_beats) bus.beat_i = 1'b1;
    seen = 0;
    lat  = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge CLK);
      if (bus.go_o) begin seen = 1; lat = n; break; end
    end
    check_eq("go_latency", 32'(lat), 32'(ADDR_SETTLE + 1));
    check_eq("sloe", 32'(bus.sloe_o), 32'(exp_w == 0));
    check_eq("state_active", 32'(bus.state_o), 3);
    ok = seen;
  endtask

  // mode 0: random-gap beats then done; mode 1: hit byte limit; mode 2: done on last beat.
  task automatic run_txn(input logic [2:0] req, input logic [2:0] blk, input int nbeats,
                         input int mode, input bit scramble, output int win);
    int exp_w;
    bit ok;
    bit b;
    int sent;
    bus.req_i   = req;
    bus.block_i = blk;
    exp_w = model_pick(req & ~blk);
    grant_and_go(exp_w, mode != 0, win, ok);
    if (ok) begin
      if (scramble) begin
        bus.req_i   = 3'($urandom);
        bus.block_i = 3'($urandom);
      end
      if (mode == 0) begin
        bus.beat_i = 1'b0;
        @(negedge CLK);
        check_eq("go_pulse", 32'(bus.go_o), 0);
        sent = 0;
        while (sent < nbeats) begin
          b = 1'($urandom_range(0, 1));
          bus.beat_i = b;
          sent += int'(b);
          @(negedge CLK);
        end
        bus.done_i = 1'b1;
        bus.beat_i = 1'($urandom_range(0, 1));
        @(negedge CLK);
        check_eq("rel_gnt", 32'(bus.gnt_o), 0);
        check_eq("rel_no_burst_end", 32'(bus.burst_end_o), 0);
        check_eq("rel_state", 32'(bus.state_o), 4);
      end else if (mode == 1) begin
        for (int i = 1; i <= MAX_BURST; i++) begin
          @(negedge CLK);
          if (i == 1) check_eq("go_pulse", 32'(bus.go_o), 0);
          if (i == MAX_BURST - 1) begin
            check_eq("pre_limit_burst_end", 32'(bus.burst_end_o), 0);
            check_eq("pre_limit_gnt", 32'(bus.gnt_o), 32'(3'b001 << exp_w));
          end
        end
        check_eq("limit_burst_end", 32'(bus.burst_end_o), 1);
        check_eq("limit_gnt", 32'(bus.gnt_o), 0);
        check_eq("limit_abort", 32'(bus.abort_o), 0);
        bus.beat_i = 1'b0;
        @(negedge CLK);
        check_eq("burst_end_pulse", 32'(bus.burst_end_o), 0);
      end else begin
        for (int i = 1; i <= MAX_BURST - 1; i++) begin
          @(negedge CLK);
          if (i == 1) check_eq("go_pulse", 32'(bus.go_o), 0);
        end
        bus.done_i = 1'b1;
        @(negedge CLK);
        check_eq("done_wins_burst_end", 32'(bus.burst_end_o), 0);
        check_eq("done_wins_gnt", 32'(bus.gnt_o), 0);
      end
    end
    bus.done_i  = 1'b0;
    bus.beat_i  = 1'b0;
    bus.req_i   = 3'b000;
    bus.block_i = 3'b000;
    txn_no++;
    $display("txn %0d req=%b blk=%b mode=%0d beats=%0d expected=%0d granted=%0d",
             txn_no, req, blk, mode, nbeats, exp_w, win);
  endtask

  int w;
  int exp3[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int exp4[3]  = '{0, 1, 0};

  initial begin
    logic [2:0] rq;
    logic [2:0] bk;
    bit ok;
    int ab_cnt;
    int lost;
    bus.req_i   = 3'b000;
    bus.block_i = 3'b000;
    bus.beat_i  = 1'b0;
    bus.done_i  = 1'b0;
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
    check_eq("rst_gnt", 32'(bus.gnt_o), 0);
    check_eq("rst_fifoadr", 32'(bus.fifoadr_o), 0);
    check_eq("rst_sloe", 32'(bus.sloe_o), 1);
    check_eq("rst_busy", 32'(bus.busy_o), 0);
    check_eq("rst_pulses", 32'({bus.go_o, bus.burst_end_o, bus.abort_o}), 0);
    check_eq("rst_state", 32'(bus.state_o), 0);
    rst_i = 1'b0;
    @(negedge CLK);

    // Round robin between ctrl engines; ctrl in wins the first tie.
    for (int i = 0; i < 3; i++) begin
      run_txn(3'b011, 3'b000, 4, 0, 0, w);
      check_eq("rr_seq", 32'(w), 32'(exp4[i]));
    end

    // Nothing eligible: arbiter must stay idle.
    bus.req_i   = 3'b110;
    bus.block_i = 3'b110;
    repeat (6) @(negedge CLK);
    check_eq("blocked_busy", 32'(bus.busy_o), 0);
    check_eq("blocked_gnt", 32'(bus.gnt_o), 0);
    bus.req_i   = 3'b000;
    bus.block_i = 3'b000;

    // Asynchronous reset in the middle of a ctrl-out transfer.
    bus.req_i = 3'b010;
    void'(model_pick(3'b010));
    grant_and_go(1, 1'b0, w, ok);
    bus.beat_i = 1'b1;
    repeat (3) @(negedge CLK);
    check_eq("pre_rst_sloe", 32'(bus.sloe_o), 0);
    rst_i = 1'b1;
    #1;
    check_eq("mid_rst_gnt", 32'(bus.gnt_o), 0);
    check_eq("mid_rst_fifoadr", 32'(bus.fifoadr_o), 0);
    check_eq("mid_rst_sloe", 32'(bus.sloe_o), 1);
    check_eq("mid_rst_busy", 32'(bus.busy_o), 0);
    check_eq("mid_rst_pulses", 32'({bus.go_o, bus.burst_end_o, bus.abort_o}), 0);
    bus.beat_i = 1'b0;
    bus.req_i  = 3'b000;
    @(negedge CLK);
    rst_i = 1'b0;
    model_reset();
    @(negedge CLK);

    // Event weighting against a waiting ctrl-out request.
    for (int i = 0; i < 10; i++) begin
      run_txn(3'b110, 3'b000, 8, 0, 0, w);
      check_eq("weight_seq", 32'(w), 32'(exp3[i]));
    end

    // Single ctrl in.
    run_txn(3'b001, 3'b000, 3, 0, 0, w);
    check_eq("single_cin", 32'(w), 0);

    // Byte limit, re-grant, and done coinciding with the last beat.
    run_txn(3'b100, 3'b000, 0, 1, 0, w);
    run_txn(3'b100, 3'b000, 0, 1, 1, w);
    run_txn(3'b100, 3'b000, 0, 2, 0, w);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      rq = 3'($urandom_range(1, 7));
      bk = 3'($urandom_range(0, 7));
      if ((rq & ~bk) == 3'b000) bk = 3'b000;
      run_txn(rq, bk, $urandom_range(0, 12), 0, 1'($urandom_range(0, 1)), w);
    end

    // Beat-less ACTIVE: watchdog abort when enabled, otherwise held grant.
    bus.req_i = 3'b100;
    w = model_pick(3'b100);
    grant_and_go(w, 1'b0, w, ok);
    bus.req_i = 3'b000;
`ifdef FX2ARB_WATCHDOG_EN
    ab_cnt = 0;
    for (int n = 1; n <= WDOG_CYCLES + 10; n++) begin
      @(negedge CLK);
      if (bus.abort_o) begin ab_cnt = n; break; end
    end
    check_eq("wdog_latency", 32'(ab_cnt), 32'(WDOG_CYCLES));
    check_eq("wdog_gnt", 32'(bus.gnt_o), 0);
    @(negedge CLK);
    check_eq("wdog_pulse", 32'(bus.abort_o), 0);
`else
    ab_cnt = 0;
    lost   = 0;
    for (int n = 1; n <= 10000; n++) begin
      @(negedge CLK);
      if (bus.abort_o) ab_cnt++;
      if (bus.gnt_o != 3'b100) lost++;
    end
    check_eq("no_wdog_abort", 32'(ab_cnt), 0);
    check_eq("no_wdog_gnt_held", 32'(lost), 0);
    bus.done_i = 1'b1;
    @(negedge CLK);
    bus.done_i = 1'b0;
    check_eq("no_wdog_release", 32'(bus.gnt_o), 0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", chk_cnt);
    $fatal(1, "timeout");
  end

endmodule
